// File: rtl/exu_multicycle_if.sv
// rtl/exu_multicycle_if.sv - IDU issue, data-memory and WBU result handshakes of exu_multicycle
interface exu_multicycle_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [OPW-1:0]    in_op;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_imm;
  logic [4:0]        in_rd;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic              out_rd_we;
  logic [XLEN-1:0]   out_rd_data;
  logic [XLEN-1:0]   out_next_pc;
  logic [1:0]        out_trap;

  modport slave (
    input  in_valid, in_op, in_pc, in_src1, in_src2, in_imm, in_use_imm, in_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
    output in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output out_valid, out_rd, out_rd_we, out_rd_data, out_next_pc, out_trap
  );

  modport master (
    output in_valid, in_op, in_pc, in_src1, in_src2, in_imm, in_use_imm, in_rd,
    output mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  out_valid, out_rd, out_rd_we, out_rd_data, out_next_pc, out_trap
  );
endinterface

// File: rtl/exu_multicycle.sv
// rtl/exu_multicycle.sv - multi-cycle execute unit: ALU/branch in one step, loads/stores via mem handshake
// Optional iterative multiply/divide built only when EXU_MDU_EN is defined.
module exu_multicycle #(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input logic             clk,
  input logic             rst_n,
  exu_multicycle_if.slave bus
);

  localparam int SHW  = $clog2(XLEN);
  localparam int OFFW = $clog2(XLEN / 8);
  localparam int MW   = XLEN / 8;

  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, MDU_BUSY, DONE} state_t;
  state_t state, state_n;

  logic [OPW-1:0]  op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q, wdata_q, rd_data_q, next_pc_q;
  logic [MW-1:0]   wmask_q;
  logic [1:0]      trap_q;
  logic            rd_we_q, store_q;

  logic [XLEN-1:0] opb, pc4, ea, rd_c, npc_c, wdata_c;
  logic [MW-1:0]   wmask_c;
  logic [1:0]      trap_c, size_c;
  logic            we_c, is_load, is_store, is_mdu, br, misal;
  logic [SHW-1:0]  shamt;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] ld_sh, ld_val;
  logic            mdu_last;
  logic [XLEN-1:0] mdu_res;

  assign opb   = bus.in_use_imm ? bus.in_imm : bus.in_src2;
  assign shamt = opb[SHW-1:0];
  assign pc4   = bus.in_pc + XLEN'(4);
  assign ea    = bus.in_src1 + bus.in_imm;
  assign off   = ea[OFFW-1:0];

  // Whole instruction is resolved from the raw inputs while IDLE, so only results are captured.
  always_comb begin
    rd_c     = '0;
    npc_c    = pc4;
    trap_c   = 2'd0;
    we_c     = (bus.in_rd != 5'd0);
    is_load  = 1'b0;
    is_store = 1'b0;
    is_mdu   = 1'b0;
    br       = 1'b0;
    size_c   = 2'd0;
    wdata_c  = '0;
    wmask_c  = '0;
    case (int'(bus.in_op))
      0:  rd_c = bus.in_src1 + opb;
      1:  rd_c = bus.in_src1 - opb;
      2:  rd_c = bus.in_src1 << shamt;
      3:  rd_c = XLEN'($signed(bus.in_src1) < $signed(opb));
      4:  rd_c = XLEN'(bus.in_src1 < opb);
      5:  rd_c = bus.in_src1 ^ opb;
      6:  rd_c = bus.in_src1 >> shamt;
      7:  rd_c = XLEN'($signed(bus.in_src1) >>> shamt);
      8:  rd_c = bus.in_src1 | opb;
      9:  rd_c = bus.in_src1 & opb;
      10: rd_c = bus.in_imm;
      11: rd_c = bus.in_pc + bus.in_imm;
      12, 13, 14, 15, 16, 17: begin
        we_c = 1'b0;
        case (int'(bus.in_op))
          12:      br = (bus.in_src1 == bus.in_src2);
          13:      br = (bus.in_src1 != bus.in_src2);
          14:      br = ($signed(bus.in_src1) < $signed(bus.in_src2));
          15:      br = ($signed(bus.in_src1) >= $signed(bus.in_src2));
          16:      br = (bus.in_src1 < bus.in_src2);
          default: br = (bus.in_src1 >= bus.in_src2);
        endcase
        if (br) npc_c = bus.in_pc + bus.in_imm;
      end
      18: begin rd_c = pc4; npc_c = bus.in_pc + bus.in_imm; end
      19: begin rd_c = pc4; npc_c = ea & ~XLEN'(1); end
      20, 23: begin is_load = 1'b1; size_c = 2'd0; end
      21, 24: begin is_load = 1'b1; size_c = 2'd1; end
      22:     begin is_load = 1'b1; size_c = 2'd2; end
      25: begin is_store = 1'b1; we_c = 1'b0; size_c = 2'd0; end
      26: begin is_store = 1'b1; we_c = 1'b0; size_c = 2'd1; end
      27: begin is_store = 1'b1; we_c = 1'b0; size_c = 2'd2; end
      28, 29, 30, 31, 32, 33, 34, 35: begin
`ifdef EXU_MDU_EN
        is_mdu = 1'b1;
`else
        trap_c = 2'd2;
`endif
      end
      36:      trap_c = 2'd1;
      default: trap_c = 2'd2;
    endcase
    misal = ((size_c == 2'd1) && ea[0]) || ((size_c == 2'd2) && (ea[1:0] != 2'b00));
    if ((is_load || is_store) && misal) trap_c = 2'd3;
    if (trap_c != 2'd0) begin
      we_c     = 1'b0;
      npc_c    = bus.in_pc;
      is_load  = 1'b0;
      is_store = 1'b0;
      is_mdu   = 1'b0;
    end
    if (is_store) begin
      case (size_c)
        2'd0:    begin wdata_c = XLEN'(bus.in_src2[7:0])  << {off, 3'b000}; wmask_c = MW'(1)    << off; end
        2'd1:    begin wdata_c = XLEN'(bus.in_src2[15:0]) << {off, 3'b000}; wmask_c = MW'(3)    << off; end
        default: begin wdata_c = XLEN'(bus.in_src2[31:0]) << {off, 3'b000}; wmask_c = MW'(4'hF) << off; end
      endcase
    end
  end

  assign ld_sh = bus.mem_rdata >> {addr_q[OFFW-1:0], 3'b000};

  always_comb begin
    case (int'(op_q))
      20:      ld_val = XLEN'($signed(ld_sh[7:0]));
      21:      ld_val = XLEN'($signed(ld_sh[15:0]));
      22:      ld_val = XLEN'($signed(ld_sh[31:0]));
      23:      ld_val = XLEN'(ld_sh[7:0]);
      24:      ld_val = XLEN'(ld_sh[15:0]);
      default: ld_val = '0;
    endcase
  end

`ifdef EXU_MDU_EN
  logic [XLEN-1:0]   m_hi, m_lo, m_opnd, m_hi_n, m_lo_n, ma, mb;
  logic [SHW-1:0]    m_cnt;
  logic              m_mul, m_neg_q, m_neg_r, sa, sb, a_neg, b_neg;
  logic [XLEN:0]     m_sum, m_rsh, m_diff;
  logic [2*XLEN-1:0] m_prod;

  always_comb begin
    sa    = (int'(bus.in_op) inside {28, 29, 30, 32, 34});
    sb    = (int'(bus.in_op) inside {28, 29, 32, 34});
    a_neg = sa & bus.in_src1[XLEN-1];
    b_neg = sb & bus.in_src2[XLEN-1];
    ma    = a_neg ? -bus.in_src1 : bus.in_src1;
    mb    = b_neg ? -bus.in_src2 : bus.in_src2;
  end

  // Multiply: {hi,lo} shifts right with lo holding the multiplier. Divide: restoring, hi=remainder, lo=quotient.
  always_comb begin
    m_sum  = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_opnd} : '0);
    m_rsh  = {m_hi, m_lo[XLEN-1]};
    m_diff = m_rsh - {1'b0, m_opnd};
    if (m_mul) begin
      m_hi_n = m_sum[XLEN:1];
      m_lo_n = {m_sum[0], m_lo[XLEN-1:1]};
    end else if (!m_diff[XLEN]) begin
      m_hi_n = m_diff[XLEN-1:0];
      m_lo_n = {m_lo[XLEN-2:0], 1'b1};
    end else begin
      m_hi_n = m_rsh[XLEN-1:0];
      m_lo_n = {m_lo[XLEN-2:0], 1'b0};
    end
  end

  assign m_prod   = m_neg_q ? -{m_hi_n, m_lo_n} : {m_hi_n, m_lo_n};
  assign mdu_last = (state == MDU_BUSY) && (m_cnt == SHW'(XLEN - 1));

  always_comb begin
    case (int'(op_q))
      28:         mdu_res = m_prod[XLEN-1:0];
      29, 30, 31: mdu_res = m_prod[2*XLEN-1:XLEN];
      32, 33:     mdu_res = m_neg_q ? -m_lo_n : m_lo_n;
      default:    mdu_res = m_neg_r ? -m_hi_n : m_hi_n;
    endcase
  end

  // Divide by zero: unsigned core already yields all-ones / dividend, so only the remainder keeps its sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_opnd <= '0; m_cnt <= '0;
      m_mul <= 1'b0; m_neg_q <= 1'b0; m_neg_r <= 1'b0;
    end else if (state == IDLE && bus.in_valid && is_mdu) begin
      m_hi    <= '0;
      m_cnt   <= '0;
      m_mul   <= (int'(bus.in_op) < 32);
      m_lo    <= (int'(bus.in_op) < 32) ? mb : ma;
      m_opnd  <= (int'(bus.in_op) < 32) ? ma : mb;
      m_neg_q <= (a_neg ^ b_neg) & ((int'(bus.in_op) < 32) || (bus.in_src2 != '0));
      m_neg_r <= a_neg;
    end else if (state == MDU_BUSY) begin
      m_hi  <= m_hi_n;
      m_lo  <= m_lo_n;
      m_cnt <= m_cnt + SHW'(1);
    end
  end
`else
  assign mdu_last = 1'b0;
  assign mdu_res  = '0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.in_valid) begin
        if (is_load || is_store) state_n = MEM_REQ;
        else if (is_mdu)         state_n = MDU_BUSY;
        else                     state_n = DONE;
      end
      MEM_REQ:  if (bus.mem_req_ready) state_n = MEM_WAIT;
      MEM_WAIT: if (bus.mem_rsp_valid) state_n = DONE;
      MDU_BUSY: if (mdu_last)          state_n = DONE;
      DONE:     if (bus.out_ready)     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rd_data_q <= '0;
      next_pc_q <= '0;
      trap_q    <= '0;
      rd_we_q   <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        op_q      <= bus.in_op;
        rd_q      <= bus.in_rd;
        addr_q    <= ea;
        wdata_q   <= wdata_c;
        wmask_q   <= wmask_c;
        rd_data_q <= rd_c;
        next_pc_q <= npc_c;
        trap_q    <= trap_c;
        rd_we_q   <= we_c;
        store_q   <= is_store;
      end else if (state == MEM_WAIT && bus.mem_rsp_valid && !store_q) begin
        rd_data_q <= ld_val;
      end else if (mdu_last) begin
        rd_data_q <= mdu_res;
      end
    end
  end

  assign bus.in_ready      = (state == IDLE);
  assign bus.mem_req_valid = (state == MEM_REQ);
  assign bus.mem_we        = bus.mem_req_valid & store_q;
  assign bus.mem_addr      = bus.mem_req_valid ? addr_q  : '0;
  assign bus.mem_wdata     = bus.mem_req_valid ? wdata_q : '0;
  assign bus.mem_wmask     = bus.mem_req_valid ? wmask_q : '0;
  assign bus.out_valid     = (state == DONE);
  assign bus.out_rd        = rd_q;
  assign bus.out_rd_we     = rd_we_q;
  assign bus.out_rd_data   = rd_data_q;
  assign bus.out_next_pc   = next_pc_q;
  assign bus.out_trap      = trap_q;

endmodule

// File: tb/tb_exu_multicycle.sv
// tb/tb_exu_multicycle.sv - directed self-checking bench for exu_multicycle
module tb_exu_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   lat;
  logic [31:0] r_data, r_npc;
  logic [1:0]  r_trap;
  logic        r_we;

  always #5 clk = ~clk;

  exu_multicycle_if #(.XLEN(32), .OPW(6)) bus ();

  exu_multicycle #(.XLEN(32), .OPW(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] imm, input logic ui, input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("issue_timeout", 0, 1);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_pc = pc; bus.in_src1 = s1;
    bus.in_src2 = s2; bus.in_imm = imm; bus.in_use_imm = ui; bus.in_rd = rd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!bus.out_valid) check("out_timeout", 0, 1);
    r_data = bus.out_rd_data; r_npc = bus.out_next_pc; r_trap = bus.out_trap; r_we = bus.out_rd_we;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic exec(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] imm, input logic ui, input logic [4:0] rd);
    issue(op, pc, s1, s2, imm, ui, rd);
    wait_out();
  endtask

  task automatic mem_phase(input int hold, input logic [31:0] rdata, input logic [31:0] e_addr,
                           input logic e_we, input logic [31:0] e_wdata, input logic [3:0] e_mask);
    int n = 0;
    @(negedge clk);
    while (!bus.mem_req_valid && n < 50) begin @(negedge clk); n++; end
    check("mreq_valid", bus.mem_req_valid, 1);
    for (int i = 0; i <= hold; i++) begin
      check("mreq_addr", bus.mem_addr, e_addr);
      check("mreq_we", bus.mem_we, e_we);
      check("mreq_wdata", bus.mem_wdata, e_wdata);
      check("mreq_wmask", bus.mem_wmask, e_mask);
      if (i < hold) @(negedge clk);
    end
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    check("mreq_drop", bus.mem_req_valid, 0);
    bus.mem_rdata = rdata; bus.mem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_op = 0; bus.in_pc = 0; bus.in_src1 = 0; bus.in_src2 = 0;
    bus.in_imm = 0; bus.in_use_imm = 0; bus.in_rd = 0; bus.mem_req_ready = 0;
    bus.mem_rsp_valid = 0; bus.mem_rdata = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mreq", bus.mem_req_valid, 0);
    check("rst_we", bus.out_rd_we, 0);
    check("rst_data", bus.out_rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // ADDI with latency and out_ready held low for 3 cycles
    issue(6'd0, 32'h8000_0000, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd3);
    @(negedge clk);
    check("addi_lat", bus.out_valid, 1);
    check("addi_data", bus.out_rd_data, 32'd2);
    check("addi_npc", bus.out_next_pc, 32'h8000_0004);
    check("addi_trap", bus.out_trap, 0);
    check("addi_we", bus.out_rd_we, 1);
    check("addi_rd", bus.out_rd, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_rd_data, 32'd2);
      check("hold_npc", bus.out_next_pc, 32'h8000_0004);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("after_xfer_ready", bus.in_ready, 1);
    check("after_xfer_valid", bus.out_valid, 0);

    exec(6'd14, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 5'd5);
    check("blt_npc", r_npc, 32'h110);
    check("blt_we", r_we, 0);
    exec(6'd16, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 5'd5);
    check("bltu_npc", r_npc, 32'h104);
    exec(6'd18, 32'h200, 32'd0, 32'd0, 32'h20, 1'b1, 5'd1);
    check("jal_data", r_data, 32'h204);
    check("jal_npc", r_npc, 32'h220);
    exec(6'd19, 32'h200, 32'h301, 32'd0, 32'h4, 1'b1, 5'd1);
    check("jalr_npc", r_npc, 32'h304);
    exec(6'd7, 32'h10, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd2);
    check("sra_data", r_data, 32'hF800_0000);
    exec(6'd1, 32'h10, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0);
    check("sub_data", r_data, 32'hFFFF_FFFE);
    check("rd0_we", r_we, 0);
    exec(6'd36, 32'h44, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2);
    check("ebreak_trap", r_trap, 2'd1);
    check("ebreak_npc", r_npc, 32'h44);
    exec(6'd40, 32'h48, 32'd0, 32'd0, 32'd0, 1'b0, 5'd2);
    check("illegal_trap", r_trap, 2'd2);

    // LB with delayed request acceptance
    issue(6'd20, 32'h300, 32'h1000, 32'd0, 32'd3, 1'b1, 5'd4);
    mem_phase(2, 32'h80AA_BBCC, 32'h1003, 1'b0, 32'd0, 4'b0000);
    wait_out();
    check("lb_data", r_data, 32'hFFFF_FF80);
    check("lb_npc", r_npc, 32'h304);
    issue(6'd24, 32'h310, 32'h1000, 32'd0, 32'd2, 1'b1, 5'd4);
    mem_phase(0, 32'h80AA_BBCC, 32'h1002, 1'b0, 32'd0, 4'b0000);
    wait_out();
    check("lhu_data", r_data, 32'h0000_80AA);
    issue(6'd26, 32'h400, 32'h1000, 32'h1234, 32'd2, 1'b1, 5'd9);
    mem_phase(0, 32'd0, 32'h1002, 1'b1, 32'h1234_0000, 4'b1100);
    wait_out();
    check("sh_we", r_we, 0);
    check("sh_npc", r_npc, 32'h404);

    // misaligned LW never requests memory
    issue(6'd22, 32'h500, 32'h1000, 32'd0, 32'd2, 1'b1, 5'd7);
    @(negedge clk);
    check("misal_mreq", bus.mem_req_valid, 0);
    check("misal_valid", bus.out_valid, 1);
    check("misal_trap", bus.out_trap, 2'd3);
    check("misal_npc", bus.out_next_pc, 32'h500);
    check("misal_we", bus.out_rd_we, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

`ifdef EXU_MDU_EN
    issue(6'd32, 32'h600, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6);
    repeat (5) @(negedge clk);
    check("busy_in_ready", bus.in_ready, 0);
    check("busy_out_valid", bus.out_valid, 0);
    wait_out();
    check("div_ovf", r_data, 32'h8000_0000);
    exec(6'd33, 32'h600, 32'd1234, 32'd0, 32'd0, 1'b0, 5'd6);
    check("divu_zero", r_data, 32'hFFFF_FFFF);
    exec(6'd31, 32'h600, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6);
    check("mulhu", r_data, 32'hFFFF_FFFE);
    exec(6'd28, 32'h600, 32'd3, 32'hFFFF_FFFC, 32'd0, 1'b0, 5'd6);
    check("mul", r_data, 32'hFFFF_FFF4);
    exec(6'd34, 32'h600, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 5'd6);
    check("rem", r_data, 32'hFFFF_FFFF);
`else
    exec(6'd28, 32'h600, 32'd3, 32'd4, 32'd0, 1'b0, 5'd6);
    check("mul_trap", r_trap, 2'd2);
    check("mul_we", r_we, 0);
    check("mul_npc", r_npc, 32'h600);
`endif

    // reset during MEM_REQ, then a stale response in IDLE
    issue(6'd22, 32'h700, 32'h1000, 32'd0, 32'd0, 1'b1, 5'd8);
    @(negedge clk);
    check("pre_rst_mreq", bus.mem_req_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mreq_drop", bus.mem_req_valid, 0);
    check("rst_idle", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF; bus.mem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stale_ready", bus.in_ready, 1);
    check("stale_valid", bus.out_valid, 0);
    exec(6'd0, 32'h800, 32'd2, 32'd3, 32'd0, 1'b0, 5'd1);
    check("post_rst_add", r_data, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
